// File: rtl/imm_extend_pipe_if.sv
// Decode-to-immediate handshake bundle: instruction/select in, extended immediate out.
// Carries both valid/ready pairs so the extender has a single bus port.
// master drives the request side and the downstream ready; slave is the extender.
interface imm_extend_pipe_if #(
  parameter int XLEN        = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                   InValid;
  logic                   InReady;
  logic [INSTR_WIDTH-1:0] Instr;
  logic [2:0]             ImmSel;
  logic                   OutValid;
  logic                   OutReady;
  logic [XLEN-1:0]        ImmExt;
  logic                   ImmIllegal;

  modport master (
    output InValid, Instr, ImmSel, OutReady,
    input  InReady, OutValid, ImmExt, ImmIllegal
  );

  modport slave (
    input  InValid, Instr, ImmSel, OutReady,
    output InReady, OutValid, ImmExt, ImmIllegal
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender (I/S/B/U/J/CSR-uimm/shamt) with a two-entry skid buffer.
// Latency: 1 cycle from accept to OutValid; throughput 1 per cycle with OutReady high.
// Backpressure: InReady is a registered state output (low only when both entries are held).
module imm_extend_pipe #(
  parameter int XLEN        = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  imm_extend_pipe_if.slave   bus
);

  localparam int SHW = (XLEN == 64) ? 6 : 5;

  localparam logic [2:0] SEL_I  = 3'b000;
  localparam logic [2:0] SEL_S  = 3'b001;
  localparam logic [2:0] SEL_B  = 3'b010;
  localparam logic [2:0] SEL_U  = 3'b011;
  localparam logic [2:0] SEL_J  = 3'b100;
  localparam logic [2:0] SEL_Z  = 3'b101;
  localparam logic [2:0] SEL_SH = 3'b110;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   main_imm_q, main_imm_d;
  logic              main_ill_q, main_ill_d;
  logic [XLEN-1:0]   skid_imm_q, skid_imm_d;
  logic              skid_ill_q, skid_ill_d;

  logic [XLEN-1:0]   new_imm;
  logic              new_ill;
  logic              in_acc;
  logic              unused_opcode;

  // The opcode field never contributes to any immediate.
  assign unused_opcode = ^bus.Instr[6:0];

  always_comb begin
    new_imm = '0;
    new_ill = 1'b0;
    case (bus.ImmSel)
      SEL_I:   new_imm = XLEN'($signed(bus.Instr[31:20]));
      SEL_S:   new_imm = XLEN'($signed({bus.Instr[31:25], bus.Instr[11:7]}));
      SEL_B:   new_imm = XLEN'($signed({bus.Instr[31], bus.Instr[7], bus.Instr[30:25],
                                        bus.Instr[11:8], 1'b0}));
      SEL_U:   new_imm = XLEN'($signed({bus.Instr[31:12], 12'b0}));
      SEL_J:   new_imm = XLEN'($signed({bus.Instr[31], bus.Instr[19:12], bus.Instr[20],
                                        bus.Instr[30:21], 1'b0}));
      SEL_Z:   new_imm = XLEN'(bus.Instr[19:15]);
      SEL_SH:  new_imm = XLEN'(bus.Instr[20 +: SHW]);
      default: new_ill = 1'b1;
    endcase
  end

  assign in_acc = bus.InValid && (state_q != ST_FULL);

  always_comb begin
    state_d    = state_q;
    main_imm_d = main_imm_q;
    main_ill_d = main_ill_q;
    skid_imm_d = skid_imm_q;
    skid_ill_d = skid_ill_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_acc) begin
          main_imm_d = new_imm;
          main_ill_d = new_ill;
          state_d    = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_acc && bus.OutReady) begin
          main_imm_d = new_imm;
          main_ill_d = new_ill;
        end else if (in_acc) begin
          // Downstream stalled: park the newcomer behind the presented entry.
          skid_imm_d = new_imm;
          skid_ill_d = new_ill;
          state_d    = ST_FULL;
        end else if (bus.OutReady) begin
          state_d    = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (bus.OutReady) begin
          main_imm_d = skid_imm_q;
          main_ill_d = skid_ill_q;
          state_d    = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      main_imm_q <= '0;
      main_ill_q <= 1'b0;
      skid_imm_q <= '0;
      skid_ill_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_imm_q <= main_imm_d;
      main_ill_q <= main_ill_d;
      skid_imm_q <= skid_imm_d;
      skid_ill_q <= skid_ill_d;
    end
  end

  assign bus.OutValid   = (state_q != ST_EMPTY);
  assign bus.InReady    = (state_q != ST_FULL);
  assign bus.ImmExt     = main_imm_q;
  assign bus.ImmIllegal = main_ill_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: format table for RV32 and RV64 instances,
// plus hand-written reset, backpressure and reset-while-full sequences.
module tb_imm_extend_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imm_extend_pipe_if #(.XLEN(32)) if32 ();
  imm_extend_pipe_if #(.XLEN(64)) if64 ();

  imm_extend_pipe #(.XLEN(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
  imm_extend_pipe #(.XLEN(64)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(if64));

  typedef struct {
    string       name;
    bit          w64;
    logic [31:0] instr;
    logic [2:0]  sel;
    logic [63:0] exp;
    logic        ill;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input bit w64, input logic v, input logic [31:0] instr,
                       input logic [2:0] sel);
    if (w64) begin
      if64.InValid = v; if64.Instr = instr; if64.ImmSel = sel;
    end else begin
      if32.InValid = v; if32.Instr = instr; if32.ImmSel = sel;
    end
  endtask

  task automatic check_out(input bit w64, input int i);
    logic [63:0] act;
    logic ov, ir, il;
    if (w64) begin
      act = if64.ImmExt; ov = if64.OutValid; ir = if64.InReady; il = if64.ImmIllegal;
    end else begin
      act = {32'b0, if32.ImmExt}; ov = if32.OutValid; ir = if32.InReady; il = if32.ImmIllegal;
    end
    chk({vecs[i].name, "_vld"}, {63'b0, ov}, 64'd1);
    chk({vecs[i].name, "_imm"}, act, vecs[i].exp);
    chk({vecs[i].name, "_ill"}, {63'b0, il}, {63'b0, vecs[i].ill});
    chk({vecs[i].name, "_rdy"}, {63'b0, ir}, 64'd1);
  endtask

  // Offers the matching table entries back to back and checks each one the
  // following cycle, so any bubble or reordering shows up as a mismatch.
  task automatic stream(input bit w64);
    int prev = -1;
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].w64 == w64) begin
        @(negedge clk);
        if (prev >= 0) check_out(w64, prev);
        drive(w64, 1'b1, vecs[i].instr, vecs[i].sel);
        prev = i;
      end
    end
    @(negedge clk);
    if (prev >= 0) check_out(w64, prev);
    drive(w64, 1'b0, 32'h0, 3'b000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{"i32",   1'b0, 32'hFFF00093, 3'b000, 64'h00000000FFFFFFFF, 1'b0};
    vecs[1]  = '{"s32",   1'b0, 32'hFE112E23, 3'b001, 64'h00000000FFFFFFFC, 1'b0};
    vecs[2]  = '{"b32",   1'b0, 32'hFE000EE3, 3'b010, 64'h00000000FFFFFFFC, 1'b0};
    vecs[3]  = '{"u32",   1'b0, 32'h12345037, 3'b011, 64'h0000000012345000, 1'b0};
    vecs[4]  = '{"j32",   1'b0, 32'h0080006F, 3'b100, 64'h0000000000000008, 1'b0};
    vecs[5]  = '{"z32",   1'b0, 32'h000FD073, 3'b101, 64'h000000000000001F, 1'b0};
    vecs[6]  = '{"sh32",  1'b0, 32'h01F09093, 3'b110, 64'h000000000000001F, 1'b0};
    vecs[7]  = '{"rsv32", 1'b0, 32'hFFFFFFFF, 3'b111, 64'h0000000000000000, 1'b1};
    vecs[8]  = '{"zneg32",1'b0, 32'h800F8073, 3'b101, 64'h000000000000001F, 1'b0};
    vecs[9]  = '{"sh6_32",1'b0, 32'h03F09093, 3'b110, 64'h000000000000001F, 1'b0};
    vecs[10] = '{"u64",   1'b1, 32'h800000B7, 3'b011, 64'hFFFFFFFF80000000, 1'b0};
    vecs[11] = '{"i64",   1'b1, 32'hFFF00093, 3'b000, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[12] = '{"sh64",  1'b1, 32'h03F09093, 3'b110, 64'h000000000000003F, 1'b0};
    vecs[13] = '{"b64",   1'b1, 32'hFE000EE3, 3'b010, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[14] = '{"rsv64", 1'b1, 32'h12345677, 3'b111, 64'h0000000000000000, 1'b1};

    drive(1'b1, 1'b0, 32'h0, 3'b000);
    if64.OutReady = 1'b1;
    if32.OutReady = 1'b1;

    // Reset held with a live offer: nothing may be captured.
    drive(1'b0, 1'b1, 32'hFFF00093, 3'b000);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_vld", {63'b0, if32.OutValid}, 64'd0);
      chk("rst_imm", {32'b0, if32.ImmExt}, 64'd0);
      chk("rst_rdy", {63'b0, if32.InReady}, 64'd1);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_vld", {63'b0, if32.OutValid}, 64'd1);
    chk("first_imm", {32'b0, if32.ImmExt}, 64'h00000000FFFFFFFF);
    drive(1'b0, 1'b0, 32'h0, 3'b000);
    @(negedge clk);
    chk("first_drain", {63'b0, if32.OutValid}, 64'd0);

    stream(1'b0);
    stream(1'b1);
    @(negedge clk);
    chk("idle32_vld", {63'b0, if32.OutValid}, 64'd0);
    chk("idle64_vld", {63'b0, if64.OutValid}, 64'd0);

    // Backpressure: A and B fill both entries, C must wait for room.
    if32.OutReady = 1'b0;
    drive(1'b0, 1'b1, 32'h00100093, 3'b000);
    @(negedge clk);
    chk("bp_a_vld", {63'b0, if32.OutValid}, 64'd1);
    chk("bp_a_imm", {32'b0, if32.ImmExt}, 64'd1);
    chk("bp_one_rdy", {63'b0, if32.InReady}, 64'd1);
    drive(1'b0, 1'b1, 32'h00200093, 3'b000);
    @(negedge clk);
    chk("bp_full_rdy", {63'b0, if32.InReady}, 64'd0);
    chk("bp_hold_a", {32'b0, if32.ImmExt}, 64'd1);
    drive(1'b0, 1'b1, 32'h00300093, 3'b000);
    @(negedge clk);
    chk("bp_c_blocked_rdy", {63'b0, if32.InReady}, 64'd0);
    chk("bp_c_hold_a", {32'b0, if32.ImmExt}, 64'd1);
    if32.OutReady = 1'b1;
    @(negedge clk);
    chk("bp_b_vld", {63'b0, if32.OutValid}, 64'd1);
    chk("bp_b_imm", {32'b0, if32.ImmExt}, 64'd2);
    chk("bp_drain_rdy", {63'b0, if32.InReady}, 64'd1);
    @(negedge clk);
    chk("bp_c_vld", {63'b0, if32.OutValid}, 64'd1);
    chk("bp_c_imm", {32'b0, if32.ImmExt}, 64'd3);
    drive(1'b0, 1'b0, 32'h0, 3'b000);
    @(negedge clk);
    chk("bp_no_dup", {63'b0, if32.OutValid}, 64'd0);

    // Reset while FULL, with a reserved select held in the presented entry.
    if32.OutReady = 1'b0;
    drive(1'b0, 1'b1, 32'h00000000, 3'b111);
    @(negedge clk);
    chk("rf_ill_set", {63'b0, if32.ImmIllegal}, 64'd1);
    drive(1'b0, 1'b1, 32'h00500093, 3'b000);
    @(negedge clk);
    chk("rf_full_rdy", {63'b0, if32.InReady}, 64'd0);
    drive(1'b0, 1'b0, 32'h0, 3'b000);
    #2 rst_n = 1'b0;
    #1;
    chk("rf_async_vld", {63'b0, if32.OutValid}, 64'd0);
    chk("rf_async_rdy", {63'b0, if32.InReady}, 64'd1);
    chk("rf_async_ill", {63'b0, if32.ImmIllegal}, 64'd0);
    chk("rf_async_imm", {32'b0, if32.ImmExt}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    if32.OutReady = 1'b1;
    @(negedge clk);
    chk("rf_no_stale0", {63'b0, if32.OutValid}, 64'd0);
    drive(1'b0, 1'b1, 32'hABCDE037, 3'b011);
    @(negedge clk);
    chk("rf_new_vld", {63'b0, if32.OutValid}, 64'd1);
    chk("rf_new_imm", {32'b0, if32.ImmExt}, 64'h00000000ABCDE000);
    drive(1'b0, 1'b0, 32'h0, 3'b000);
    @(negedge clk);
    chk("rf_no_stale1", {63'b0, if32.OutValid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
